// File: rtl/approximate_accuracy_controllable_divider.sv
// approximate_accuracy_controllable_divider
//
// Iterative radix-2 restoring divider for unsigned operands. It shares the
// accuracy control byte used by the accuracy-controllable multiplier. In
// approximate mode the k least-significant quotient iterations are skipped,
// which shortens latency. The remainder is still the exact
// dividend - quotient*divisor.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (abandons any operation)
//   start      request, sampled only while idle or in the done cycle
//   input_1    dividend (unsigned, WIDTH bits)
//   input_2    divisor  (unsigned, WIDTH bits)
//   accuracy   [7] approximate enable, [4:0] requested skip count, [6:5] ignored
//   busy       high while iterating (stall request to the pipeline)
//   done       one-cycle completion pulse
//   quotient   result quotient, held until the next completion or reset
//   remainder  result remainder, held until the next completion or reset
module approximate_accuracy_controllable_divider #(
  parameter int WIDTH    = 32,
  parameter int SKIP_MAX = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [7:0]       accuracy,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int         IW         = $clog2(WIDTH);
  localparam logic [4:0] SKIP_MAX_C = 5'(SKIP_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of skipped low quotient bits: zero in exact mode, otherwise the
  // requested count saturated at SKIP_MAX.
  function automatic logic [4:0] sat_skip(input logic [7:0] acc);
    logic [4:0] req;
    req = acc[4:0];
    if (!acc[7]) begin
      sat_skip = 5'd0;
    end else if (req > SKIP_MAX_C) begin
      sat_skip = SKIP_MAX_C;
    end else begin
      sat_skip = req;
    end
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qacc_q, qacc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [IW-1:0]    k_q, k_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_sub;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] low_mask;

  // Bits 6:5 of the accuracy byte carry no meaning for this unit.
  logic unused_acc;
  assign unused_acc = ^accuracy[6:5];

  // One restoring step on dividend bit idx_q. The partial remainder is
  // always below the divisor, so it fits in WIDTH bits; the shifted value
  // needs one extra bit. When the subtraction is taken the true difference
  // is below the divisor, so a WIDTH-bit subtraction is exact.
  always_comb begin
    r_shift  = {rem_q, dvd_q[idx_q]};
    q_bit    = (r_shift >= {1'b0, dvs_q});
    r_sub    = r_shift[WIDTH-1:0] - dvs_q;
    r_next   = q_bit ? r_sub : r_shift[WIDTH-1:0];
    q_next   = (qacc_q << 1) | WIDTH'(q_bit);
    low_mask = ~({WIDTH{1'b1}} << k_q);
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    k_d     = k_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d  = input_1;
          dvs_d  = input_2;
          k_d    = IW'(sat_skip(accuracy));
          idx_d  = IW'(WIDTH - 1);
          rem_d  = '0;
          qacc_d = '0;
          if (input_2 == '0) begin
            // Divide by zero resolves immediately with DIVU/REMU results.
            state_d = DONE;
            quo_d   = '1;
            rmd_d   = input_1;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d  = r_next;
        qacc_d = q_next;
        idx_d  = idx_q - 1'b1;
        if (idx_q == k_q) begin
          // Skipped dividend bits pass straight into the remainder, which
          // keeps dividend == quotient*divisor + remainder exact.
          state_d = DONE;
          quo_d   = q_next << k_q;
          rmd_d   = (r_next << k_q) | (dvd_q & low_mask);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    rem_q  <= rem_d;
    qacc_q <= qacc_d;
    k_q    <= k_d;
    idx_q  <= idx_d;
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_approximate_accuracy_controllable_divider.sv
module tb_approximate_accuracy_controllable_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] input_1;
  logic [31:0] input_2;
  logic [7:0]  accuracy;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  approximate_accuracy_controllable_divider #(
    .WIDTH(32),
    .SKIP_MAX(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .input_1(input_1),
    .input_2(input_2),
    .accuracy(accuracy),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
  );

  typedef struct {
    string       name;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [7:0]  acc;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at the negedge following the accept edge. Returns the number of
  // busy cycles seen and the number of edges since the accept edge
  // (inclusive) at which done was observed.
  task automatic wait_done(input string nm, output int busy_cnt, output int lat);
    logic timeout;
    busy_cnt = 0;
    lat      = 1;
    timeout  = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (timeout) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d edges", nm, lat);
    end else begin
      chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  // Launch one operation and scramble the inputs right after acceptance.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [7:0] acc);
    @(negedge clk);
    input_1  = a;
    input_2  = b;
    accuracy = acc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    input_1  = 32'hDEAD_BEEF;
    input_2  = 32'h0000_0000;
    accuracy = 8'h9F;
  endtask

  initial begin
    int bc;
    int lat;

    vecs.push_back('{"exact_100_7",     32'd100,        32'd7,          8'h00, 32'd14,         32'd2,          32});
    vecs.push_back('{"approx_1000_3",   32'd1000,       32'd3,          8'h84, 32'd320,        32'd40,         28});
    vecs.push_back('{"noen_1000_3",     32'd1000,       32'd3,          8'h04, 32'd333,        32'd1,          32});
    vecs.push_back('{"maxskip_9F",      32'h8000_0000,  32'd1,          8'h9F, 32'h8000_0000,  32'd0,          1});
    vecs.push_back('{"maxskip_FF",      32'h8000_0000,  32'd1,          8'hFF, 32'h8000_0000,  32'd0,          1});
    vecs.push_back('{"div0_55",         32'd55,         32'd0,          8'h00, 32'hFFFF_FFFF,  32'd55,         0});
    vecs.push_back('{"allones",         32'hFFFF_FFFF,  32'hFFFF_FFFF,  8'h00, 32'd1,          32'd0,          32});
    vecs.push_back('{"approx_k8",       32'hFFFF_FFFF,  32'd1,          8'h88, 32'hFFFF_FF00,  32'h0000_00FF,  24});
    vecs.push_back('{"small_5_10",      32'd5,          32'd10,         8'h00, 32'd0,          32'd5,          32});
    vecs.push_back('{"exact_hex",       32'h1234_5678,  32'h0000_1000,  8'h00, 32'h0001_2345,  32'h0000_0678,  32});
    vecs.push_back('{"approx_k16",      32'h1234_5678,  32'h0000_1000,  8'h90, 32'h0001_0000,  32'h0234_5678,  16});
    vecs.push_back('{"bits65_only",     32'd100,        32'd7,          8'h60, 32'd14,         32'd2,          32});

    reset    = 1'b1;
    start    = 1'b0;
    input_1  = '0;
    input_2  = '0;
    accuracy = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q",    quotient,  32'd0);
    chk("reset_r",    remainder, 32'd0);

    foreach (vecs[i]) begin
      launch(vecs[i].dvd, vecs[i].dvs, vecs[i].acc);
      wait_done(vecs[i].name, bc, lat);
      chk({vecs[i].name, "_busy_cycles"}, 32'(bc),  32'(vecs[i].exp_busy));
      chk({vecs[i].name, "_latency"},     32'(lat), 32'(vecs[i].exp_busy + 1));
      chk({vecs[i].name, "_q"},           quotient,  vecs[i].exp_q);
      chk({vecs[i].name, "_r"},           remainder, vecs[i].exp_r);
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"},  32'(done), 32'd0);
      chk({vecs[i].name, "_q_hold"},      quotient,  vecs[i].exp_q);
    end

    // start pulsed mid-run must be ignored
    launch(32'd100, 32'd7, 8'h00);
    repeat (4) @(negedge clk);
    input_1  = 32'd9;
    input_2  = 32'd2;
    accuracy = 8'h84;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("midrun_still_busy", 32'(busy), 32'd1);
    wait_done("midrun", bc, lat);
    chk("midrun_q", quotient,  32'd14);
    chk("midrun_r", remainder, 32'd2);

    // accept in the DONE cycle: back-to-back 9 / 2
    input_1  = 32'd9;
    input_2  = 32'd2;
    accuracy = 8'h00;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("b2b_done_dropped", 32'(done), 32'd0);
    chk("b2b_busy",         32'(busy), 32'd1);
    chk("b2b_q_hold_run",   quotient,  32'd14);
    wait_done("b2b", bc, lat);
    chk("b2b_busy_cycles", 32'(bc),  32'd32);
    chk("b2b_latency",     32'(lat), 32'd33);
    chk("b2b_q", quotient,  32'd4);
    chk("b2b_r", remainder, 32'd1);
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 32'd0);

    // reset in the 10th busy cycle
    launch(32'd1000, 32'd3, 8'h00);
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_q",    quotient,  32'd0);
    chk("midreset_r",    remainder, 32'd0);
    repeat (2) @(negedge clk);
    chk("postreset_idle_busy", 32'(busy), 32'd0);
    launch(32'd100, 32'd7, 8'h00);
    wait_done("postreset", bc, lat);
    chk("postreset_busy_cycles", 32'(bc), 32'd32);
    chk("postreset_q", quotient,  32'd14);
    chk("postreset_r", remainder, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
